// File: rtl/vlsu_txn_sched.sv
// Vector load/store transaction scheduler: splits requests into bus-sized chunks,
// issues them round-robin across slots and retires a slot once its chunks complete.
module vlsu_txn_sched #(
    parameter int unsigned NrSlots  = 4,
    parameter int unsigned AddrBits = 32,
    parameter int unsigned BusBytes = 64,
    parameter int unsigned LenBits  = 16,
    parameter int unsigned OutstMax = 15,
    parameter int unsigned SlotW    = $clog2(NrSlots)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [3:0]                req_mode_i,
    input  logic [AddrBits-1:0]       req_addr_i,
    input  logic [AddrBits-1:0]       req_stride_i,
    input  logic [1:0]                req_eew_i,
    input  logic [LenBits-1:0]        req_nbytes_i,
    input  logic [3:0]                req_vd_i,
    output logic                      iss_valid_o,
    input  logic                      iss_ready_i,
    output logic [AddrBits-1:0]       iss_addr_o,
    output logic [$clog2(BusBytes):0] iss_size_o,
    output logic [SlotW-1:0]          iss_slot_o,
    input  logic                      cpl_valid_i,
    input  logic [SlotW-1:0]          cpl_slot_i,
    output logic                      done_valid_o,
    output logic [SlotW-1:0]          done_slot_o,
    output logic [3:0]                done_vd_o,
    output logic                      done_err_o,
    output logic                      busy_o
);
    localparam int unsigned OffW = $clog2(BusBytes);
    localparam int unsigned SzW  = OffW + 1;
    localparam int unsigned OutW = $clog2(OutstMax + 1);

    typedef enum logic [1:0] { SLOT_FREE, SLOT_ISSUE, SLOT_DRAIN } slot_state_e;
    typedef enum logic [3:0] {
        MODE_INCR  = 4'b0001,
        MODE_STRD  = 4'b0010,
        MODE_ROW2D = 4'b0100,
        MODE_CLN2D = 4'b1000
    } mode_oh_t;

    slot_state_e         state_q  [NrSlots];
    logic [AddrBits-1:0] addr_q   [NrSlots];
    logic [LenBits-1:0]  rem_q    [NrSlots];
    logic [3:0]          mode_q   [NrSlots];
    logic [AddrBits-1:0] stride_q [NrSlots];
    logic [1:0]          eew_q    [NrSlots];
    logic [3:0]          vd_q     [NrSlots];
    logic                err_q    [NrSlots];
    logic [OutW-1:0]     outst_q  [NrSlots];

    logic [SlotW-1:0]    rr_ptr_q;
    logic                hold_q;
    logic [SlotW-1:0]    hold_slot_q;

    logic [NrSlots-1:0]  free_vec, elig_vec, retire_vec, iss_hit, cpl_hit;
    logic [SlotW-1:0]    alloc_idx, rr_pick, grant, done_idx;
    logic                elig_any, done_any, iss_vld, iss_fire, req_fire, req_ok;
    logic [AddrBits-1:0] g_addr, nxt_addr;
    logic [LenBits-1:0]  g_rem, lim, chunk;

    // Slot scan, allocation and round-robin arbitration
    always_comb begin
        int unsigned idx;
        idx        = 0;
        free_vec   = '0;
        elig_vec   = '0;
        retire_vec = '0;
        alloc_idx  = '0;
        done_idx   = '0;
        rr_pick    = '0;
        elig_any   = 1'b0;
        for (int unsigned i = 0; i < NrSlots; i++) begin
            free_vec[i]   = state_q[i] == SLOT_FREE;
            elig_vec[i]   = state_q[i] == SLOT_ISSUE && outst_q[i] < OutW'(OutstMax);
            retire_vec[i] = state_q[i] == SLOT_DRAIN && outst_q[i] == '0;
        end
        for (int unsigned i = NrSlots; i > 0; i--) begin
            if (free_vec[i-1])   alloc_idx = SlotW'(i - 1);
            if (retire_vec[i-1]) done_idx  = SlotW'(i - 1);
        end
        for (int unsigned k = 1; k <= NrSlots; k++) begin
            idx = (32'(rr_ptr_q) + k) % NrSlots;
            if (!elig_any && elig_vec[SlotW'(idx)]) begin
                elig_any = 1'b1;
                rr_pick  = SlotW'(idx);
            end
        end
        // A stalled grant is pinned so new eligible slots cannot steal it
        grant       = hold_q ? hold_slot_q : rr_pick;
        iss_vld     = hold_q | elig_any;
        done_any    = |retire_vec;
        req_ready_o = |free_vec;
        busy_o      = ~&free_vec;
        iss_fire    = iss_vld & iss_ready_i;
        req_fire    = req_valid_i & req_ready_o;
        req_ok      = (req_mode_i == MODE_INCR) || (req_mode_i == MODE_STRD);
    end

    // Chunk sizing and output datapath
    always_comb begin
        iss_hit = '0;
        cpl_hit = '0;
        g_addr  = addr_q[grant];
        g_rem   = rem_q[grant];
        if (mode_q[grant] == MODE_STRD) begin
            lim = LenBits'(1) << eew_q[grant];
        end else begin
            lim = LenBits'(BusBytes) - LenBits'(g_addr[OffW-1:0]);
        end
        chunk = (g_rem < lim) ? g_rem : lim;
        if (mode_q[grant] == MODE_STRD) begin
            nxt_addr = g_addr + stride_q[grant];
        end else begin
            nxt_addr = g_addr + AddrBits'(chunk);
        end
        for (int unsigned i = 0; i < NrSlots; i++) begin
            iss_hit[i] = iss_fire && grant == SlotW'(i);
            cpl_hit[i] = cpl_valid_i && cpl_slot_i == SlotW'(i) && outst_q[i] != '0;
        end
        iss_valid_o  = iss_vld;
        iss_addr_o   = iss_vld ? g_addr : '0;
        iss_size_o   = iss_vld ? SzW'(chunk) : '0;
        iss_slot_o   = iss_vld ? grant : '0;
        done_valid_o = done_any;
        done_slot_o  = done_idx;
        done_vd_o    = done_any ? vd_q[done_idx] : '0;
        done_err_o   = done_any & err_q[done_idx];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrSlots; i++) begin
                state_q[i]  <= SLOT_FREE;
                addr_q[i]   <= '0;
                rem_q[i]    <= '0;
                mode_q[i]   <= '0;
                stride_q[i] <= '0;
                eew_q[i]    <= '0;
                vd_q[i]     <= '0;
                err_q[i]    <= 1'b0;
                outst_q[i]  <= '0;
            end
            rr_ptr_q    <= SlotW'(NrSlots - 1);
            hold_q      <= 1'b0;
            hold_slot_q <= '0;
        end else begin
            hold_q      <= iss_vld & ~iss_ready_i;
            hold_slot_q <= grant;
            if (iss_fire) rr_ptr_q <= grant;
            for (int unsigned i = 0; i < NrSlots; i++) begin
                if (iss_hit[i] && !cpl_hit[i]) begin
                    outst_q[i] <= outst_q[i] + 1'b1;
                end else if (!iss_hit[i] && cpl_hit[i]) begin
                    outst_q[i] <= outst_q[i] - 1'b1;
                end
                if (iss_hit[i]) begin
                    addr_q[i] <= nxt_addr;
                    rem_q[i]  <= rem_q[i] - chunk;
                    if (rem_q[i] == chunk) state_q[i] <= SLOT_DRAIN;
                end
                if (done_any && done_idx == SlotW'(i)) state_q[i] <= SLOT_FREE;
                if (req_fire && alloc_idx == SlotW'(i)) begin
                    state_q[i]  <= (req_ok && req_nbytes_i != '0) ? SLOT_ISSUE : SLOT_DRAIN;
                    addr_q[i]   <= req_addr_i;
                    rem_q[i]    <= req_nbytes_i;
                    mode_q[i]   <= req_mode_i;
                    stride_q[i] <= req_stride_i;
                    eew_q[i]    <= req_eew_i;
                    vd_q[i]     <= req_vd_i;
                    err_q[i]    <= ~req_ok;
                    outst_q[i]  <= '0;
                end
            end
        end
    end

endmodule

// File: doc/vlsu_txn_sched.md
VLSU_TXN_SCHED -- requirements
Module: vlsu_txn_sched

Interface
REQ-001 SHALL have parameter NrSlots, default 4 (txnCtrlNum), the number of transaction slots.
REQ-002 SHALL have parameter AddrBits, default 32, the address width.
REQ-003 SHALL have parameter BusBytes, default 64 (busBytes), the bus width in bytes.
REQ-004 SHALL have parameter LenBits, default 16, the request byte-count width.
REQ-005 SHALL have parameter OutstMax, default 15, the maximum outstanding issues per slot; SlotW=$clog2(NrSlots).
REQ-006 SHALL have ports:
clk_i  in  1  clock; single clock domain, all logic on rising edge
rst_ni  in  1  reset; synchronous, active-low
req_valid_i/req_ready_o  in/out  1  request handshake
req_mode_i  in  4  mode_oh_t one-hot
req_addr_i  in  AddrBits  base byte address
req_stride_i  in  AddrBits  byte stride, two's complement (STRD only)
req_eew_i  in  2  element size = 1<<eew bytes (STRD only)
req_nbytes_i  in  LenBits  total bytes
req_vd_i  in  4  destination vreg tag
iss_valid_o/iss_ready_i  out/in  1  issue handshake
iss_addr_o  out  AddrBits  chunk address
iss_size_o  out  $clog2(BusBytes)+1  chunk bytes, 1..BusBytes
iss_slot_o  out  SlotW  issuing slot
cpl_valid_i  in  1  one issued chunk completed
cpl_slot_i  in  SlotW  slot of completed chunk
done_valid_o  out  1  slot retire pulse, no backpressure
done_slot_o  out  SlotW  retiring slot
done_vd_o  out  4  vd of retiring slot
done_err_o  out  1  retired request had unsupported mode
busy_o  out  1  any slot not FREE

Function
REQ-007 Each slot SHALL hold state {FREE, ISSUE, DRAIN}, addr, remaining bytes, mode, stride, eew, vd, err, and an outstanding counter.
REQ-008 req_ready_o SHALL equal (any slot FREE); an accepted request SHALL load the lowest-index FREE slot.
REQ-009 On accept: nbytes>0 and mode INCR/STRD -> ISSUE; nbytes=0 -> DRAIN, err=0; ROW2D, CLN2D or non-one-hot mode -> DRAIN, err=1, no issues.
REQ-010 Slot eligible for issue iff ISSUE and outstanding<OutstMax; earliest iss_valid_o is the cycle after acceptance.
REQ-011 Grant SHALL be round-robin: first eligible slot after last-granted pointer; pointer updates only on iss handshake; reset pointer NrSlots-1 (slot 0 first).
REQ-012 While iss_valid_o=1 and iss_ready_i=0, granted slot and all iss_* outputs SHALL stay stable.
REQ-013 INCR chunk: size=min(remaining, BusBytes-(addr mod BusBytes)); on handshake addr+=size.
REQ-014 STRD chunk: size=min(1<<eew, remaining); on handshake addr+=stride modulo 2^AddrBits.
REQ-015 On handshake: remaining-=size, outstanding+=1; remaining reaching 0 moves slot to DRAIN.
REQ-016 cpl_valid_i SHALL decrement that slot's outstanding; issue and completion on the same slot in one cycle leave it unchanged; cpl to a slot with outstanding=0 SHALL be ignored.
REQ-017 Slot in DRAIN with outstanding=0 is retire-ready; done_valid_o SHALL be asserted combinationally for the lowest-index retire-ready slot, one per cycle; that slot becomes FREE next edge, others wait.
REQ-018 A slot freed at edge N SHALL be allocatable from cycle N onward (req_ready_o reflects registered state).
REQ-019 Final cpl at cycle M SHALL give done_valid_o at M+1 absent contention.

Reset
REQ-020 rst_ni=0 at an edge SHALL set all slots FREE, outstanding 0, pointer NrSlots-1; in-flight requests discarded.
REQ-021 During/after reset: req_ready_o=1, iss_valid_o=0, done_valid_o=0, busy_o=0, all other outputs 0.

Verification
REQ-022 INCR addr=0x1030, nbytes=100, iss_ready=1 -> chunks (0x1030,16),(0x1040,64),(0x1080,20); 3 cpl -> done vd, err=0.
REQ-023 STRD addr=0x100, stride=-8, eew=2, nbytes=10 -> (0x100,4),(0xF8,4),(0xF0,2).
REQ-024 Four INCR requests to slots 0-3, iss_ready=1 -> issue order 0,1,2,3,0,...; req_ready_o=0 until a done.
REQ-025 iss_ready=0 for 5 cycles with new request arriving -> iss_* outputs unchanged, no grant switch.
REQ-026 ROW2D request and nbytes=0 request -> no issue; done pulses next cycle, err=1 and err=0 respectively.
REQ-027 No cpl for 16 issues to one slot -> stalls after 15 outstanding; one cpl -> issue resumes; rst_ni=0 mid-stream -> REQ-021 values next cycle.
